core_db_enc: RTL and testbench

Synchronous Hamming(7,4) encoder on the data-bucket-to-router path. It accepts an 8-bit bucket word in the format | 4-bit data | 4-bit IP |. It emits an 11-bit router flit carrying the IP nibble plus a single-error-correcting codeword for the data nibble. It is the transmit counterpart of the bucket-side decoder: every flit it produces, with at most one flipped codeword bit, decodes back to the original data nibble. A 2-entry output buffer, a flit counter and a test error-injection port make it usable as both a datapath block and a decoder stimulus source.

---
 rtl/core_db_pkg.sv | 46 ++++
 rtl/core_db_fifo.sv | 73 +++++++
 rtl/core_db_enc.sv | 63 ++++++
 tb/tb_core_db_enc.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_db_pkg.sv
// Shared definitions for the Hamming(7,4) data-bucket link: field widths,
// codeword bit positions, flit layout and the encode/syndrome helpers.
package core_db_pkg;

    localparam int DW   = 8;   // bucket word: [7:4] data, [3:0] IP
    localparam int FW   = 11;  // router flit: [10:7] IP, [6:0] codeword
    localparam int CW_W = 7;

    // Codeword bit index = Hamming position - 1
    localparam int P1 = 0;
    localparam int P2 = 1;
    localparam int D1 = 2;
    localparam int P4 = 3;
    localparam int D2 = 4;
    localparam int D3 = 5;
    localparam int D4 = 6;

    typedef struct packed {
        logic [3:0]      ip;
        logic [CW_W-1:0] cw;
    } flit_t;

    function automatic logic [CW_W-1:0] ham74_encode(input logic [3:0] nibble);
        logic [CW_W-1:0] cw;
        cw     = '0;
        cw[D1] = nibble[0];
        cw[D2] = nibble[1];
        cw[D3] = nibble[2];
        cw[D4] = nibble[3];
        cw[P1] = nibble[0] ^ nibble[1] ^ nibble[3];
        cw[P2] = nibble[0] ^ nibble[2] ^ nibble[3];
        cw[P4] = nibble[1] ^ nibble[2] ^ nibble[3];
        return cw;
    endfunction

    // Syndrome is the position (1..7) of a single flipped bit, 0 if clean;
    // kept here so the bucket-side decoder uses the same bit map.
    function automatic logic [2:0] ham74_syndrome(input logic [CW_W-1:0] cw);
        logic [2:0] syn;
        syn[0] = cw[P1] ^ cw[D1] ^ cw[D2] ^ cw[D4];
        syn[1] = cw[P2] ^ cw[D1] ^ cw[D3] ^ cw[D4];
        syn[2] = cw[P4] ^ cw[D2] ^ cw[D3] ^ cw[D4];
        return syn;
    endfunction

endpackage

// File: rtl/core_db_fifo.sv
// Small valid/ready FIFO with registered storage; outputs depend only on
// state, so there is no combinational path from the write to the read side.
module core_db_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 11
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] in_data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] out_data_o
);

    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q,  count_d;
    logic          push, pop;

    assign in_ready_o  = (count_q != FULL_CNT);
    assign out_valid_o = (count_q != '0);
    assign push        = in_valid_i & in_ready_o;
    assign pop         = out_valid_o & out_ready_i;

    // Empty slots read as zero so out_data is 0 after reset and between flits
    assign out_data_o  = out_valid_o ? mem_q[rd_ptr_q] : '0;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // Power-of-two depth makes the pointer wrap a natural overflow
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: non-blocking (<=) in every clocked block so all registers update
    // from pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage has no reset; occupancy alone defines which entries are
    // live, and a resettable array would cost a reset tree for nothing.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= in_data_i;
    end

    a_count_bound: assert property (@(posedge clk) disable iff (!rst_n)
        count_q <= FULL_CNT);
    a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
        (count_q == FULL_CNT) |-> !push);

endmodule

// File: rtl/core_db_enc.sv
// Hamming(7,4) encoder for the bucket-to-router path with optional single-bit
// error injection, a small output buffer and a wrapping delivered-flit counter.
module core_db_enc
    import core_db_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNTW  = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DW-1:0]   in_data,
    input  logic [2:0]      inj_pos,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [FW-1:0]   out_data,
    output logic [CNTW-1:0] flit_cnt
);

    flit_t           flit_d;
    logic [CW_W-1:0] inj_mask;
    logic [CNTW-1:0] flit_cnt_q, flit_cnt_d;
    logic            pop;

    // Injection is applied after parity so the flit carries a genuine
    // single-bit error at Hamming position inj_pos.
    always_comb begin
        inj_mask = '0;
        if (inj_pos != 3'd0) inj_mask = CW_W'(1) << (inj_pos - 3'd1);
        flit_d.ip = in_data[3:0];
        flit_d.cw = ham74_encode(in_data[7:4]) ^ inj_mask;
    end

    core_db_fifo #(
        .DEPTH (DEPTH),
        .W     (FW)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (flit_d),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data)
    );

    assign pop = out_valid & out_ready;

    always_comb begin
        flit_cnt_d = flit_cnt_q;
        if (pop) flit_cnt_d = flit_cnt_q + CNTW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) flit_cnt_q <= '0;
        else        flit_cnt_q <= flit_cnt_d;
    end

    assign flit_cnt = flit_cnt_q;

endmodule

// File: tb/tb_core_db_enc.sv
// Directed bench for core_db_enc: encode values, injection sweep checked via
// an independent Hamming decoder, backpressure, streaming wrap and async reset.
module tb_core_db_enc;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic [2:0]  inj_pos;
    logic        out_valid;
    logic        out_ready;
    logic [10:0] out_data;
    logic [15:0] flit_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    core_db_enc #(.DEPTH(2), .CNTW(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .inj_pos   (inj_pos),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .flit_cnt  (flit_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bench-side decoder, written from the position definition of Hamming code
    function automatic logic [2:0] tb_syn(input logic [6:0] c);
        logic s1, s2, s4;
        s1 = c[0] ^ c[2] ^ c[4] ^ c[6];
        s2 = c[1] ^ c[2] ^ c[5] ^ c[6];
        s4 = c[3] ^ c[4] ^ c[5] ^ c[6];
        return {s4, s2, s1};
    endfunction

    function automatic logic [3:0] tb_decode(input logic [6:0] c);
        logic [6:0] fixed;
        logic [2:0] s;
        fixed = c;
        s = tb_syn(c);
        if (s != 3'd0) fixed[s - 3'd1] = ~fixed[s - 3'd1];
        return {fixed[6], fixed[5], fixed[4], fixed[2]};
    endfunction

    task automatic accept_word(input logic [7:0] d, input logic [2:0] p);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        inj_pos  = p;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #3;
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready);
        else n_pass++;
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid);
        else n_pass++;
        n_checks++;
        if (out_data !== 11'h000) $display("FAIL reset_out_data got %h want 000", out_data);
        else n_pass++;
        n_checks++;
        if (flit_cnt !== 16'd0) $display("FAIL reset_flit_cnt got %0d want 0", flit_cnt);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_encode();
        out_ready = 1'b1;
        accept_word(8'hA5, 3'd0);
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 11'h2D2)
            $display("FAIL encode_a5 got valid=%b data=%h want 1/2d2", out_valid, out_data);
        else n_pass++;
        n_checks++;
        if (flit_cnt !== 16'd0) $display("FAIL encode_cnt_before got %0d want 0", flit_cnt);
        else n_pass++;
        @(posedge clk); #1;
        n_checks++;
        if (flit_cnt !== 16'd1 || out_valid !== 1'b0)
            $display("FAIL encode_cnt_after got cnt=%0d valid=%b want 1/0", flit_cnt, out_valid);
        else n_pass++;
    endtask

    task automatic test_corners();
        accept_word(8'h00, 3'd0);
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 11'h000)
            $display("FAIL corner_00 got valid=%b data=%h want 1/000", out_valid, out_data);
        else n_pass++;
        @(posedge clk); #1;
        accept_word(8'hF3, 3'd0);
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 11'h1FF)
            $display("FAIL corner_f3 got valid=%b data=%h want 1/1ff", out_valid, out_data);
        else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_injection();
        accept_word(8'hA5, 3'd3);
        n_checks++;
        if (out_data !== 11'h2D6) $display("FAIL inject_a5_p3 got %h want 2d6", out_data);
        else n_pass++;
        n_checks++;
        if (tb_decode(out_data[6:0]) !== 4'hA)
            $display("FAIL inject_a5_decode got %h want a", tb_decode(out_data[6:0]));
        else n_pass++;
        @(posedge clk); #1;
        n_checks++;
        if (flit_cnt !== 16'd4) $display("FAIL inject_flit_cnt got %0d want 4", flit_cnt);
        else n_pass++;
    endtask

    // Back-to-back accepts: every nibble at every injection position; the
    // syndrome must equal the injected position and the data must decode.
    task automatic test_inject_sweep();
        logic [3:0] nib;
        logic [3:0] ip;
        for (int n = 0; n < 16; n++) begin
            for (int p = 0; p < 8; p++) begin
                nib = 4'(n);
                ip  = ~nib;
                accept_word({nib, ip}, 3'(p));
                n_checks++;
                if (out_valid !== 1'b1 || out_data[10:7] !== ip ||
                    tb_syn(out_data[6:0]) !== 3'(p) || tb_decode(out_data[6:0]) !== nib)
                    $display("FAIL sweep n=%0d p=%0d got valid=%b flit=%h syn=%0d want ip=%h syn=%0d data=%h",
                             n, p, out_valid, out_data, tb_syn(out_data[6:0]), ip, p, nib);
                else n_pass++;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int bubbles;
        int bad;
        int stalls;
        logic [7:0] w;
        do_reset();
        out_ready = 1'b1;
        bubbles = 0;
        bad     = 0;
        stalls  = 0;
        for (int i = 0; i < 70000; i++) begin
            w = 8'(i * 7 + (i >> 8));
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = w;
            inj_pos  = 3'd0;
            @(posedge clk); #1;
            if (in_ready !== 1'b1) stalls++;
            if (out_valid !== 1'b1) bubbles++;
            else if (out_data[10:7] !== w[3:0] || tb_syn(out_data[6:0]) !== 3'd0 ||
                     tb_decode(out_data[6:0]) !== w[7:4]) bad++;
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (bubbles != 0 || stalls != 0)
            $display("FAIL stream_bubbles got bubbles=%0d stalls=%0d want 0/0", bubbles, stalls);
        else n_pass++;
        n_checks++;
        if (bad != 0) $display("FAIL stream_data got %0d bad flits want 0", bad);
        else n_pass++;
        n_checks++;
        if (flit_cnt !== 16'd4464) $display("FAIL stream_wrap got %0d want 4464", flit_cnt);
        else n_pass++;
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL stream_drain got valid=%b want 0", out_valid);
        else n_pass++;
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b0;
        accept_word(8'h12, 3'd0);
        accept_word(8'h34, 3'd0);
        n_checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0 || flit_cnt !== 16'd4464)
            $display("FAIL midrst_pre got valid=%b ready=%b cnt=%0d want 1/0/4464",
                     out_valid, in_ready, flit_cnt);
        else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || flit_cnt !== 16'd0 || in_ready !== 1'b1)
            $display("FAIL midrst_async got valid=%b cnt=%0d ready=%b want 0/0/1",
                     out_valid, flit_cnt, in_ready);
        else n_pass++;
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        accept_word(8'hA5, 3'd0);
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 11'h2D2)
            $display("FAIL midrst_first got valid=%b data=%h want 1/2d2", out_valid, out_data);
        else n_pass++;
        @(posedge clk); #1;
        n_checks++;
        if (flit_cnt !== 16'd1) $display("FAIL midrst_cnt got %0d want 1", flit_cnt);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        do_reset();
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'h12;
        inj_pos  = 3'd0;
        @(posedge clk); #1;
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL bp_ready_one got %b want 1", in_ready);
        else n_pass++;
        @(negedge clk);
        in_data = 8'h34;
        @(posedge clk); #1;
        n_checks++;
        if (in_ready !== 1'b0) $display("FAIL bp_full got %b want 0", in_ready);
        else n_pass++;
        @(negedge clk);
        in_data = 8'h56;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            n_checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 11'h107)
                $display("FAIL bp_hold k=%0d got ready=%b valid=%b data=%h want 0/1/107",
                         k, in_ready, out_valid, out_data);
            else n_pass++;
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (out_data !== 11'h21E || in_ready !== 1'b1 || flit_cnt !== 16'd1)
            $display("FAIL bp_pop1 got data=%h ready=%b cnt=%0d want 21e/1/1",
                     out_data, in_ready, flit_cnt);
        else n_pass++;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 11'h32D || flit_cnt !== 16'd2)
            $display("FAIL bp_pop2 got valid=%b data=%h cnt=%0d want 1/32d/2",
                     out_valid, out_data, flit_cnt);
        else n_pass++;
        @(posedge clk); #1;
        n_checks++;
        if (out_valid !== 1'b0 || flit_cnt !== 16'd3)
            $display("FAIL bp_pop3 got valid=%b cnt=%0d want 0/3", out_valid, flit_cnt);
        else n_pass++;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        inj_pos   = 3'd0;
        out_ready = 1'b0;
        test_reset();
        test_encode();
        test_corners();
        test_injection();
        test_inject_sweep();
        test_back_to_back();
        test_reset_midstream();
        test_backpressure();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
